// File: rtl/des_pkg.sv
// Shared DES sequencing definitions: controller state encoding, round count and
// the per-round C/D rotate schedules for encryption and decryption.
package des_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int NUM_ROUNDS = 16;

  // Decrypt starts with 0 because the registered C/D value after PC-1 already equals K16's C/D.
  localparam logic [1:0] ENC_SHIFT [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_SHIFT [NUM_ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:0] shift_amount(input logic [3:0] rnd, input logic mode);
    logic [1:0] amt;
    if (mode) begin
      amt = DEC_SHIFT[rnd];
    end else begin
      amt = ENC_SHIFT[rnd];
    end
    return amt;
  endfunction

endpackage

// File: rtl/key_shift_sched.sv
// Combinational C/D rotate lookup: (round, mode) -> (rotate amount, direction).
module key_shift_sched
  import des_pkg::*;
(
  input  logic [3:0] round_idx,
  input  logic       mode,
  output logic [1:0] key_shift,
  output logic       key_dir
);

  // Table lookup; direction follows mode (right rotation when decrypting).
  always_comb begin
    key_shift = shift_amount(round_idx, mode);
    key_dir   = mode;
  end

endmodule

// File: rtl/round_ctrl.sv
// Sequencing controller for the iterative DES core: LOAD, 16 rounds, FINAL swap,
// FP drain and a one-cycle done pulse. All outputs come straight from flops.
module round_ctrl
  import des_pkg::*;
#(
  parameter int FP_LAT = 1
) (
  input  logic       round_ctrl_clk,
  input  logic       round_ctrl_rst,
  input  logic       round_ctrl_start,
  input  logic       round_ctrl_decrypt,
  output logic       round_ctrl_busy,
  output logic       round_ctrl_ld_init,
  output logic       round_ctrl_key_ld,
  output logic       round_ctrl_rnd_en,
  output logic [1:0] round_ctrl_key_shift,
  output logic       round_ctrl_key_dir,
  output logic [3:0] round_ctrl_round,
  output logic       round_ctrl_swap,
  output logic       round_ctrl_done
);

  // DRAIN reuses the round counter; counter width limits FP_LAT to 17.
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(FP_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;

  logic       busy_q, busy_d;
  logic       ld_init_q, ld_init_d;
  logic       rnd_en_q, rnd_en_d;
  logic [1:0] key_shift_q, key_shift_d;
  logic       key_dir_q, key_dir_d;
  logic [3:0] round_q, round_d;
  logic       swap_q, swap_d;
  logic       done_q, done_d;

  logic [1:0] sched_shift;
  logic       sched_dir;

  // Looked up on the next-cycle round and mode so the command can be registered.
  key_shift_sched u_sched (
    .round_idx (cnt_d),
    .mode      (mode_d),
    .key_shift (sched_shift),
    .key_dir   (sched_dir)
  );

  // Next-state, counter and mode logic; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (round_ctrl_start) begin
          state_d = ST_LOAD;
          mode_d  = round_ctrl_decrypt;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_ROUND;
        cnt_d   = 4'd0;
      end
      ST_ROUND: begin
        if (cnt_q == LAST_ROUND) begin
          state_d = ST_FINAL;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FINAL: begin
        cnt_d = 4'd0;
        if (FP_LAT == 1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        mode_d  = 1'b0;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    ld_init_d   = (state_d == ST_LOAD);
    rnd_en_d    = (state_d == ST_ROUND);
    round_d     = rnd_en_d ? cnt_d : 4'd0;
    key_shift_d = rnd_en_d ? sched_shift : 2'd0;
    key_dir_d   = busy_d ? sched_dir : 1'b0;
    swap_d      = (state_d == ST_FINAL);
    done_d      = (state_d == ST_DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge round_ctrl_clk) begin
    if (round_ctrl_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      ld_init_q   <= 1'b0;
      rnd_en_q    <= 1'b0;
      key_shift_q <= 2'd0;
      key_dir_q   <= 1'b0;
      round_q     <= 4'd0;
      swap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      ld_init_q   <= ld_init_d;
      rnd_en_q    <= rnd_en_d;
      key_shift_q <= key_shift_d;
      key_dir_q   <= key_dir_d;
      round_q     <= round_d;
      swap_q      <= swap_d;
      done_q      <= done_d;
    end
  end

  assign round_ctrl_busy      = busy_q;
  assign round_ctrl_ld_init   = ld_init_q;
  assign round_ctrl_key_ld    = ld_init_q;
  assign round_ctrl_rnd_en    = rnd_en_q;
  assign round_ctrl_key_shift = key_shift_q;
  assign round_ctrl_key_dir   = key_dir_q;
  assign round_ctrl_round     = round_q;
  assign round_ctrl_swap      = swap_q;
  assign round_ctrl_done      = done_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: FP_LAT=1 and FP_LAT=3 instances share stimulus and are
// compared every cycle against a timeline model, plus vector table and corner sequences.
module tb_round_ctrl;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic decr = 1'b0;

  logic busy_a, ld_a, kld_a, en_a, dir_a, swap_a, done_a;
  logic [1:0] sh_a;
  logic [3:0] rnd_a;
  logic busy_b, ld_b, kld_b, en_b, dir_b, swap_b, done_b;
  logic [1:0] sh_b;
  logic [3:0] rnd_b;
  logic [12:0] vec_a, vec_b;

  int errors = 0;
  int checks = 0;
  int ka = 0;
  int kb = 0;
  logic ma = 1'b0;
  logic mb = 1'b0;

  int enc_sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_sched [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic        rst;
    logic        start;
    logic        dec;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  round_ctrl #(.FP_LAT(LAT_A)) dut_a (
    .round_ctrl_clk(clk), .round_ctrl_rst(rst), .round_ctrl_start(start),
    .round_ctrl_decrypt(decr), .round_ctrl_busy(busy_a), .round_ctrl_ld_init(ld_a),
    .round_ctrl_key_ld(kld_a), .round_ctrl_rnd_en(en_a), .round_ctrl_key_shift(sh_a),
    .round_ctrl_key_dir(dir_a), .round_ctrl_round(rnd_a), .round_ctrl_swap(swap_a),
    .round_ctrl_done(done_a)
  );

  round_ctrl #(.FP_LAT(LAT_B)) dut_b (
    .round_ctrl_clk(clk), .round_ctrl_rst(rst), .round_ctrl_start(start),
    .round_ctrl_decrypt(decr), .round_ctrl_busy(busy_b), .round_ctrl_ld_init(ld_b),
    .round_ctrl_key_ld(kld_b), .round_ctrl_rnd_en(en_b), .round_ctrl_key_shift(sh_b),
    .round_ctrl_key_dir(dir_b), .round_ctrl_round(rnd_b), .round_ctrl_swap(swap_b),
    .round_ctrl_done(done_b)
  );

  assign vec_a = {busy_a, ld_a, kld_a, en_a, sh_a, dir_a, rnd_a, swap_a, done_a};
  assign vec_b = {busy_b, ld_b, kld_b, en_b, sh_b, dir_b, rnd_b, swap_b, done_b};

  function automatic logic [12:0] pk(input logic busy, input logic ld, input logic en,
                                     input logic [1:0] sh, input logic dir,
                                     input logic [3:0] rnd, input logic swap, input logic done);
    return {busy, ld, ld, en, sh, dir, rnd, swap, done};
  endfunction

  // k = cycles since the accepted start (0 = idle); every output is a function of k.
  function automatic logic [12:0] model_vec(input int k, input logic m, input int lat);
    logic act;
    logic [1:0] sh;
    logic [3:0] rn;
    act = (k >= 2) && (k <= 17);
    sh = 2'd0;
    rn = 4'd0;
    if (act) begin
      rn = 4'(k - 2);
      sh = m ? 2'(dec_sched[k - 2]) : 2'(enc_sched[k - 2]);
    end
    return pk(k != 0, k == 1, act, sh, (k != 0) && m, rn, k == 18, k == 18 + lat);
  endfunction

  task automatic check_vec(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d);
    rst = r;
    start = s;
    decr = d;
    @(posedge clk);
    if (r) begin
      ka = 0; ma = 1'b0;
    end else if (ka == 0) begin
      if (s) begin ka = 1; ma = d; end
    end else if (ka == 18 + LAT_A) begin
      ka = 0;
    end else begin
      ka++;
    end
    if (r) begin
      kb = 0; mb = 1'b0;
    end else if (kb == 0) begin
      if (s) begin kb = 1; mb = d; end
    end else if (kb == 18 + LAT_B) begin
      kb = 0;
    end else begin
      kb++;
    end
    #1;
    check_vec("model_a", vec_a, model_vec(ka, ma, LAT_A));
    check_vec("model_b", vec_b, model_vec(kb, mb, LAT_B));
  endtask

  initial begin
    int n_done;
    int done_at;
    int lat;
    int off_swap, off_done, off_idle;
    bit found;
    int dq_a[$];
    int dq_b[$];

    // Expected vectors for the FP_LAT=1 instance: reset, then one encrypt and one decrypt run.
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 13'd0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 13'd0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 13'd0});
    for (int mi = 0; mi < 2; mi++) begin
      logic m;
      m = mi[0];
      tbl.push_back(vec_t'{1'b0, 1'b1, m, pk(1'b1, 1'b1, 1'b0, 2'd0, m, 4'd0, 1'b0, 1'b0)});
      for (int r = 0; r < 16; r++) begin
        tbl.push_back(vec_t'{1'b0, r == 3, ~m,
          pk(1'b1, 1'b0, 1'b1, m ? 2'(dec_sched[r]) : 2'(enc_sched[r]), m, 4'(r), 1'b0, 1'b0)});
      end
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 2'd0, m, 4'd0, 1'b1, 1'b0)});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 2'd0, m, 4'd0, 1'b0, 1'b1)});
      tbl.push_back(vec_t'{1'b0, 1'b1, ~m, 13'd0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 13'd0});
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].dec);
      check_vec($sformatf("vec%0d", i), vec_a, tbl[i].exp);
    end

    // Start pulses during ROUND and DONE are ignored: exactly one done.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_done = 0;
    done_at = -1;
    for (int i = 1; i <= 25; i++) begin
      step(1'b0, (i == 5) || (i == 19), 1'b1);
      if (done_a) begin n_done++; done_at = i; end
    end
    check_int("ignored_start_done_count", n_done, 1);
    check_int("ignored_start_done_at", done_at, 18);

    // Start held high: done spacing is 19+FP_LAT.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (done_a) dq_a.push_back(i);
      if (done_b) dq_b.push_back(i);
    end
    check_int("held_count_a", dq_a.size(), 3);
    check_int("held_count_b", dq_b.size(), 3);
    for (int i = 1; i < dq_a.size(); i++) check_int("held_gap_a", dq_a[i] - dq_a[i-1], 20);
    for (int i = 1; i < dq_b.size(); i++) check_int("held_gap_b", dq_b[i] - dq_b[i-1], 22);

    // Reset at round 7 aborts silently; a fresh start then completes normally.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (en_a && rnd_a == 4'd7) found = 1'b1;
    end
    check_int("abort_reached_round7", int'(found), 1);
    step(1'b1, 1'b0, 1'b0);
    check_vec("abort_outputs_a", vec_a, 13'd0);
    check_vec("abort_outputs_b", vec_b, 13'd0);
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done_a || done_b) n_done++;
    end
    check_int("abort_no_done", n_done, 0);
    step(1'b0, 1'b1, 1'b0);
    lat = 1;
    while (!done_a && lat < 40) begin
      step(1'b0, 1'b0, 1'b0);
      lat++;
    end
    check_int("restart_done_latency", lat, 19);

    // FP_LAT=3 instance: swap at +18, done at +21, busy low at +22.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    off_swap = -1; off_done = -1; off_idle = -1;
    for (int off = 2; off <= 26; off++) begin
      step(1'b0, 1'b0, 1'b0);
      if (swap_b && off_swap < 0) off_swap = off;
      if (done_b && off_done < 0) off_done = off;
      if (!busy_b && off_idle < 0) off_idle = off;
    end
    check_int("lat3_swap_offset", off_swap, 18);
    check_int("lat3_done_offset", off_done, 21);
    check_int("lat3_idle_offset", off_idle, 22);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Sequencing controller for the iterative DES core. It accepts a start request and runs the load, 16-round and final-swap sequence on the shared L/R round registers and C/D key registers. It then drives the {R16,L16} pre-output into the registered final-permutation stage and pulses done once the permuted block is valid. It contains no datapath: it only issues enables, selects and key-shift commands to the round, key-schedule and final-permutation blocks.

## Interface
- FP_LAT, 1, register latency (cycles, ≥1) of the final-permutation stage; sets the spacing from FINAL to done
- round_ctrl_clk  in  1  single clock, all state on rising edge
- round_ctrl_rst  in  1  reset, synchronous, active-high
- round_ctrl_start  in  1  operation request; sampled only in IDLE
- round_ctrl_decrypt  in  1  mode (0 encrypt, 1 decrypt); latched with accepted start
- round_ctrl_busy  out  1  high from LOAD through DONE inclusive
- round_ctrl_ld_init  out  1  L/R registers load the IP output (LOAD only)
- round_ctrl_key_ld  out  1  C/D registers load the PC-1 output (LOAD only)
- round_ctrl_rnd_en  out  1  L/R and C/D update with one round (ROUND only)
- round_ctrl_key_shift  out  2  C/D rotate amount this round: 0, 1 or 2
- round_ctrl_key_dir  out  1  rotate direction: 0 left (encrypt), 1 right (decrypt)
- round_ctrl_round  out  4  current round index 0..15; 0 outside ROUND
- round_ctrl_swap  out  1  present {R16,L16} to the final-permutation input (FINAL only)
- round_ctrl_done  out  1  one-cycle pulse; final-permutation output valid this cycle

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DRAIN, DONE.
- IDLE → LOAD on start=1. Latch decrypt into mode_q.
- LOAD → ROUND unconditionally. Round counter cleared to 0.
- ROUND: rnd_en=1 each cycle and the counter increments. At counter 15, go to FINAL.
- FINAL: swap=1 for one cycle. If FP_LAT=1 go to DONE, else go to DRAIN.
- DRAIN: lasts FP_LAT-1 cycles (counted with the round counter), then go to DONE.
- DONE → IDLE unconditionally. start is ignored in DONE.
- Key rotation is shift-then-use: in ROUND cycle r, the rotated C/D value feeds both PC-2 and the C/D register update.
- Encrypt schedule (r=0..15), left rotation: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt schedule, right rotation: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- key_dir = mode_q while busy, 0 otherwise. key_shift = 0 outside ROUND.
- start and decrypt are don't-care in every state except IDLE. No queuing.

## Timing
- Reset: on any cycle with rst=1, the next state is IDLE and the counter and mode_q are cleared. All outputs are 0 from the following cycle.
- Reset mid-operation aborts with no done pulse. Datapath register contents are don't-care afterwards.
- Start accepted at cycle t gives this sequence:
  - LOAD at t+1.
  - ROUND at t+2..t+17, with round=0..15.
  - FINAL at t+18; the final-permutation stage captures at the end of t+18.
  - done at t+18+FP_LAT (t+19 for the default).
- Throughput with start held high: one block every 19+FP_LAT cycles. The next LOAD follows the IDLE cycle after DONE.
- All outputs are registered or decoded from state and counter only. There is no combinational path from start or decrypt to any output.

## Structure
- Shared package des_pkg holds:
  - state enum encoding
  - NUM_ROUNDS = 16
  - the 16-entry encrypt and decrypt rotate-schedule constants, as 2-bit values (reused by the key-schedule testbench model)
- One sub-module, key_shift_sched: combinational lookup (round, mode) → (key_shift, key_dir). Instantiated once, and also usable for a one-round-per-cycle key expansion elsewhere.

## Test plan
- Reset: assert rst for 2 cycles, including one cycle with start=1 → every output 0 and busy stays 0.
- Encrypt, FP_LAT=1: start at t → LOAD at t+1, round 0..15 at t+2..t+17, key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0, swap at t+18, done at t+19. Integrated with the datapath, key 133457799BBCDFF1 and plaintext 0123456789ABCDEF give 85E813540F0AB405.
- Decrypt: same timing, key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=1. Input 85E813540F0AB405 with the same key decrypts to 0123456789ABCDEF.
- Start pulses at t+5 and t+19 (during ROUND and DONE) → ignored, exactly one done. Start held high → done pulses exactly 20 cycles apart.
- rst=1 at round=7 → IDLE next cycle with all outputs 0 and no done. A new start then completes normally with done after 19 cycles.
- FP_LAT=3 build: start at t → swap at t+18, done at t+21, busy deasserts at t+22.
